// File: rtl/block_accumulator.sv
// block_accumulator
//   Requests one block read from the multiplier (single-cycle EN_blockRead).
//   It then sums the streamed memVal_data words into an ACCW-bit accumulator.
//   The sum, the word count and a timeout flag go downstream over a
//   valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           request a block reduction (sampled only in IDLE)
//   busy            high whenever the FSM is not in IDLE
//   EN_blockRead    one-cycle block-read request
//   VALID_memVal    memVal_data is valid (used only in COLLECT)
//   memVal_data     streamed block word, zero-extended into the sum
//   result_valid    result fields valid; held until result_ready
//   result_ready    downstream accepts the result
//   result_sum      sum of received words, modulo 2^ACCW
//   result_count    number of words received
//   result_err      block ended by timeout (count < 2^LOGDEPTH)
//   result_max/min  running max/min of received words (0 when no words)
//
// Optional feature macro: BLOCK_ACC_MINMAX_EN adds result_max/result_min.
module block_accumulator #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH    = 32,
  parameter int ACCW     = 40,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                EN_blockRead,
  input  logic                VALID_memVal,
  input  logic [WIDTH-1:0]    memVal_data,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [ACCW-1:0]     result_sum,
  output logic [LOGDEPTH:0]   result_count,
  output logic                result_err
`ifdef BLOCK_ACC_MINMAX_EN
  ,
  output logic [WIDTH-1:0]    result_max,
  output logic [WIDTH-1:0]    result_min
`endif
);

  localparam int GAPW = $clog2(TIMEOUT + 1);
  // Count value just before the last word of a full block.
  localparam logic [LOGDEPTH:0] CNT_LAST = (LOGDEPTH+1)'((1 << LOGDEPTH) - 1);
  // Gap value just before the idle cycle that completes the timeout.
  localparam logic [GAPW-1:0]   GAP_LAST = GAPW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, HOLD} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_en;
  logic                r_vld;
  logic                r_err;
  logic [ACCW-1:0]     r_acc;
  logic [LOGDEPTH:0]   r_cnt;
  logic [GAPW-1:0]     r_gap;
  logic [ACCW-1:0]     r_sum;
  logic [LOGDEPTH:0]   r_rcnt;

  logic [ACCW-1:0]     w_acc_nxt;
  logic [LOGDEPTH:0]   w_cnt_nxt;
  logic                w_full;
  logic                w_tout;

  assign w_acc_nxt = r_acc + ACCW'(memVal_data);
  assign w_cnt_nxt = r_cnt + (LOGDEPTH+1)'(1);
  assign w_full    = (r_cnt == CNT_LAST);
  assign w_tout    = (r_gap == GAP_LAST);

`ifdef BLOCK_ACC_MINMAX_EN
  logic [WIDTH-1:0]    r_max;
  logic [WIDTH-1:0]    r_min;
  logic [WIDTH-1:0]    r_rmax;
  logic [WIDTH-1:0]    r_rmin;
  logic [WIDTH-1:0]    w_max_nxt;
  logic [WIDTH-1:0]    w_min_nxt;

  assign w_max_nxt  = (memVal_data > r_max) ? memVal_data : r_max;
  assign w_min_nxt  = (memVal_data < r_min) ? memVal_data : r_min;
  assign result_max = r_rmax;
  assign result_min = r_rmin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_sum   <= '0;
      r_rcnt  <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
      r_max   <= '0;
      r_min   <= '0;
      r_rmax  <= '0;
      r_rmin  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= REQ;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
          end
        end
        REQ: begin
          r_en    <= 1'b0;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_gap   <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
          r_max   <= '0;
          r_min   <= '1;
`endif
          r_state <= COLLECT;
        end
        COLLECT: begin
          if (VALID_memVal) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_gap <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
`endif
            // Results come from the next-state values so the last word is included.
            if (w_full) begin
              r_state <= HOLD;
              r_vld   <= 1'b1;
              r_sum   <= w_acc_nxt;
              r_rcnt  <= w_cnt_nxt;
              r_err   <= 1'b0;
`ifdef BLOCK_ACC_MINMAX_EN
              r_rmax  <= w_max_nxt;
              r_rmin  <= w_min_nxt;
`endif
            end
          end else begin
            r_gap <= r_gap + GAPW'(1);
            if (w_tout) begin
              r_state <= HOLD;
              r_vld   <= 1'b1;
              r_sum   <= r_acc;
              r_rcnt  <= r_cnt;
              r_err   <= 1'b1;
`ifdef BLOCK_ACC_MINMAX_EN
              // An empty block reports zero rather than the all-ones min seed.
              r_rmax  <= (r_cnt == '0) ? '0 : r_max;
              r_rmin  <= (r_cnt == '0) ? '0 : r_min;
`endif
            end
          end
        end
        HOLD: begin
          if (r_vld && result_ready) begin
            r_state <= IDLE;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign EN_blockRead = r_en;
  assign result_valid = r_vld;
  assign result_sum   = r_sum;
  assign result_count = r_rcnt;
  assign result_err   = r_err;

endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator
//   Scoreboard bench for block_accumulator. Expected results are queued as
//   each block is driven and compared at each valid/ready transfer.
//   Define BLOCK_ACC_MINMAX_EN to also cover result_max/result_min.
module tb_block_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        EN_blockRead;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        result_valid;
  logic        result_ready;
  logic [39:0] result_sum;
  logic [6:0]  result_count;
  logic        result_err;
`ifdef BLOCK_ACC_MINMAX_EN
  logic [31:0] result_max;
  logic [31:0] result_min;
`endif

  block_accumulator #(.LOGDEPTH(6), .WIDTH(32), .ACCW(40), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_sum   (result_sum),
    .result_count (result_count),
    .result_err   (result_err)
`ifdef BLOCK_ACC_MINMAX_EN
    ,
    .result_max   (result_max),
    .result_min   (result_min)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] sum;
    logic [6:0]  cnt;
    logic        err;
    logic [31:0] mx;
    logic [31:0] mn;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  // Reference model of the block currently being driven.
  logic [39:0] m_sum;
  logic [6:0]  m_cnt;
  logic [31:0] m_max;
  logic [31:0] m_min;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic err);
    exp_t e;
    e.sum = m_sum;
    e.cnt = m_cnt;
    e.err = err;
    e.mx  = (m_cnt == 0) ? 32'h0 : m_max;
    e.mn  = (m_cnt == 0) ? 32'h0 : m_min;
    sb_q.push_back(e);
  endtask

  task automatic begin_block();
    m_sum = '0;
    m_cnt = '0;
    m_max = '0;
    m_min = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_en", EN_blockRead, 1);
    chk("req_busy", busy, 1);
    tick();
    chk("en_pulse_end", EN_blockRead, 0);
  endtask

  task automatic word(input logic [31:0] d);
    VALID_memVal = 1'b1;
    memVal_data  = d;
    m_sum = m_sum + {8'h0, d};
    m_cnt = m_cnt + 7'd1;
    if (d > m_max) m_max = d;
    if (d < m_min) m_min = d;
    tick();
    VALID_memVal = 1'b0;
  endtask

  task automatic idle(input int n);
    VALID_memVal = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full-block ending: expectation queued just before the last word.
  task automatic last_word(input logic [31:0] d);
    chk("vld_before_last", result_valid, 0);
    m_sum = m_sum + {8'h0, d};
    m_cnt = m_cnt + 7'd1;
    if (d > m_max) m_max = d;
    if (d < m_min) m_min = d;
    push_exp(1'b0);
    VALID_memVal = 1'b1;
    memVal_data  = d;
    tick();
    VALID_memVal = 1'b0;
    chk("vld_after_last", result_valid, 1);
  endtask

  task automatic timeout_end();
    idle(15);
    chk("vld_before_tout", result_valid, 0);
    push_exp(1'b1);
    idle(1);
    chk("vld_after_tout", result_valid, 1);
  endtask

  task automatic finish_block();
    tick();
    chk("vld_drop", result_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Scoreboard monitor: a transfer occurs at the next edge when both are high.
  always begin
    @(posedge clk);
    #2;
    if (!rst && result_valid && result_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_result", {63'h0, result_valid}, 64'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sum", result_sum, e.sum);
        chk("count", result_count, e.cnt);
        chk("err", result_err, e.err);
`ifdef BLOCK_ACC_MINMAX_EN
        chk("max", result_max, e.mx);
        chk("min", result_min, e.mn);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    start = 1'b0;
    VALID_memVal = 1'b0;
    memVal_data = '0;
    result_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_en", EN_blockRead, 0);
    chk("rst_vld", result_valid, 0);
    chk("rst_err", result_err, 0);
    chk("rst_sum", result_sum, 0);
    chk("rst_cnt", result_count, 0);
    rst = 1'b0;
    tick();

    // Test 1: 64 words of 1 back-to-back.
    begin_block();
    for (int i = 0; i < 63; i++) word(32'd1);
    last_word(32'd1);
    chk("t1_sum", result_sum, 64);
    finish_block();

    // Test 2: 64 words of all-ones, no overflow in 40 bits.
    begin_block();
    for (int i = 0; i < 63; i++) word(32'hFFFF_FFFF);
    last_word(32'hFFFF_FFFF);
    chk("t2_sum", result_sum, 40'h3F_FFFF_FFC0);
    finish_block();

    // Test 3: words 1..10 then timeout.
    begin_block();
    for (int i = 1; i <= 10; i++) word(i);
    timeout_end();
    chk("t3_sum", result_sum, 55);
    finish_block();

    // Test 4a: 64 random words separated by 15-cycle gaps, no timeout.
    begin_block();
    for (int i = 0; i < 63; i++) begin
      word($urandom);
      idle(15);
    end
    d = $urandom;
    last_word(d);
    finish_block();

    // Test 4b: no words at all.
    begin_block();
    timeout_end();
    finish_block();

    // VALID_memVal ignored in IDLE and REQ.
    VALID_memVal = 1'b1;
    memVal_data = 32'd7;
    tick();
    tick();
    m_sum = '0;
    m_cnt = '0;
    m_max = '0;
    m_min = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_en", EN_blockRead, 1);
    tick();
    VALID_memVal = 1'b0;
    for (int i = 0; i < 5; i++) word(32'd1);
    timeout_end();
    finish_block();

    // Test 5: backpressure in HOLD with a start pulse, then start in handshake cycle.
    begin_block();
    result_ready = 1'b0;
    for (int i = 0; i < 63; i++) word($urandom);
    d = $urandom;
    last_word(d);
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      tick();
      chk("hold_vld", result_valid, 1);
      chk("hold_sum", result_sum, m_sum);
      chk("hold_cnt", result_count, m_cnt);
      chk("hold_en", EN_blockRead, 0);
    end
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("xfer_vld", result_valid, 0);
    chk("xfer_sum_hold", result_sum, m_sum);
    chk("xfer_busy", busy, 0);
    tick();
    chk("hs_start_ign_en", EN_blockRead, 0);
    chk("hs_start_ign_busy", busy, 0);

    // Test 6: reset mid-block, then a clean block of 2s.
    begin_block();
    for (int i = 0; i < 30; i++) word(32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", EN_blockRead, 0);
    chk("abort_vld", result_valid, 0);
    chk("abort_sum", result_sum, 0);
    chk("abort_cnt", result_count, 0);
    chk("abort_err", result_err, 0);
    begin_block();
    for (int i = 0; i < 63; i++) word(32'd2);
    last_word(32'd2);
    chk("t6_sum", result_sum, 128);
    finish_block();

    // Words 5, 9, 3 then timeout (max 9 / min 3 when the feature is built).
    begin_block();
    word(32'd5);
    word(32'd9);
    word(32'd3);
    timeout_end();
`ifdef BLOCK_ACC_MINMAX_EN
    chk("mm_max", result_max, 9);
    chk("mm_min", result_min, 3);
`endif
    finish_block();

    tick();
    chk("sb_pending", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
